ssemi_decimator_sequencer: RTL and testbench

Controller that brings up and supervises the three-stage ADC decimator (CIC, compensation FIR, halfband). On a start request it streams the control word and all coefficients from a synchronous coefficient ROM onto the decimator's configuration bus, then enables the datapath and confirms that output samples appear. While running it watches the decimator error flag and an output-activity watchdog. It sits between the system control/ROM and the decimator top-level.

---
 rtl/ssemi_decimator_sequencer_pkg.sv | 26 ++
 rtl/ssemi_seq_watchdog.sv | 31 +++
 rtl/ssemi_decimator_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_ssemi_decimator_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ssemi_decimator_sequencer_pkg.sv
// rtl/ssemi_decimator_sequencer_pkg.sv - shared states, error codes and config-address map
package ssemi_decimator_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE, RD, CAP, WR, ENA, WAIT1, RUN, ERROR, HOLDOFF
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_DATAPATH = 2'd1,
    ERR_WATCHDOG = 2'd2,
    ERR_ABORT    = 2'd3
  } err_type_t;

  localparam logic [7:0] CTRL_BASE = 8'h00;
  localparam logic [7:0] FIR_BASE  = 8'h10;
  localparam logic [7:0] HB_BASE   = 8'h80;

  // ROM index -> decimator configuration address
  function automatic logic [7:0] map_addr(input logic [6:0] k, input logic [6:0] fir_taps);
    if (k == 7'd0) return CTRL_BASE;
    else if (k <= fir_taps) return FIR_BASE + {1'b0, k - 7'd1};
    else return HB_BASE + {1'b0, k - 7'd1 - fir_taps};
  endfunction

endpackage

// File: rtl/ssemi_seq_watchdog.sv
// rtl/ssemi_seq_watchdog.sv - loadable up-counter with clear, enable and terminal-count flag
module ssemi_seq_watchdog #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_terminal,
  output logic             o_tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear)       count_d = '0;
    else if (i_load)   count_d = i_load_value;
    else if (i_enable) count_d = count_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) count_q <= '0;
    else       count_q <= count_d;
  end

  assign o_tc = (count_q == i_terminal);

endmodule

// File: rtl/ssemi_decimator_sequencer.sv
// rtl/ssemi_decimator_sequencer.sv - decimator coefficient loader and run supervisor
// Optional auto-restart after datapath/watchdog errors: SSEMI_DEC_SEQ_AUTO_RESTART_EN
module ssemi_decimator_sequencer
  import ssemi_decimator_sequencer_pkg::*;
#(
  parameter int FIR_TAPS        = 32,
  parameter int HALFBAND_TAPS   = 15,
  parameter int WATCHDOG_CYCLES = 4096,
  parameter int RESTART_HOLDOFF = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [6:0]  o_rom_addr,
  output logic        o_rom_rd,
  input  logic [31:0] i_rom_data,
  output logic        o_config_valid,
  output logic [7:0]  o_config_addr,
  output logic [31:0] o_config_data,
  input  logic        i_config_ready,
  output logic        o_enable,
  input  logic        i_dec_valid,
  input  logic        i_dec_error,
  output logic        o_running,
  output logic        o_busy,
  output logic        o_error,
  output logic [1:0]  o_error_type,
`ifdef SSEMI_DEC_SEQ_AUTO_RESTART_EN
  output logic [7:0]  o_restart_count,
`endif
  output logic [6:0]  o_words_written
);

  localparam logic [6:0] LAST_K = 7'(FIR_TAPS + HALFBAND_TAPS);
  localparam logic [6:0] FIR_K  = 7'(FIR_TAPS);

  if (FIR_TAPS < 4 || FIR_TAPS > 64 || HALFBAND_TAPS < 5 || HALFBAND_TAPS > 31 ||
      HALFBAND_TAPS % 2 == 0 || WATCHDOG_CYCLES < 2 || WATCHDOG_CYCLES > 65535 ||
      RESTART_HOLDOFF < 1 || RESTART_HOLDOFF > 255) begin : g_param_err
    $error("ssemi_decimator_sequencer: parameter out of range");
  end

  seq_state_t  state_q, state_d;
  err_type_t   err_q, err_d;
  logic [6:0]  k_q, k_d, rom_addr_q, rom_addr_d, words_q, words_d;
  logic [7:0]  cfg_addr_q, cfg_addr_d;
  logic [31:0] cfg_data_q, cfg_data_d;
  logic        rom_rd_q, rom_rd_d, cfg_valid_q, cfg_valid_d, enable_q, enable_d;
  logic        running_q, running_d, busy_q, busy_d, error_q, error_d;
  logic        wd_clear, wd_enable, wd_tc, start_load, auto_go;

  ssemi_seq_watchdog #(.WIDTH(16)) u_watchdog (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(wd_clear), .i_load(1'b0),
    .i_load_value(16'd0), .i_enable(wd_enable),
    .i_terminal(16'(WATCHDOG_CYCLES)), .o_tc(wd_tc)
  );

`ifdef SSEMI_DEC_SEQ_AUTO_RESTART_EN
  logic [7:0] restart_cnt_q, restart_cnt_d;
  logic       ho_tc;

  // Held at zero outside ERROR, so the count starts fresh on every error entry
  ssemi_seq_watchdog #(.WIDTH(8)) u_holdoff (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(state_q != ERROR), .i_load(1'b0),
    .i_load_value(8'd0), .i_enable(state_q == ERROR),
    .i_terminal(8'(RESTART_HOLDOFF - 1)), .o_tc(ho_tc)
  );
  assign auto_go = ho_tc && (err_q == ERR_DATAPATH || err_q == ERR_WATCHDOG);
  assign o_restart_count = restart_cnt_q;
`else
  assign auto_go = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    k_d         = k_q;
    rom_addr_d  = rom_addr_q;
    rom_rd_d    = 1'b0;
    words_d     = words_q;
    cfg_valid_d = cfg_valid_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    enable_d    = enable_q;
    running_d   = running_q;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;
    start_load  = 1'b0;
`ifdef SSEMI_DEC_SEQ_AUTO_RESTART_EN
    restart_cnt_d = restart_cnt_q;
`endif
    if (i_abort) begin
      cfg_valid_d = 1'b0;
      enable_d    = 1'b0;
      running_d   = 1'b0;
      if (state_q == RD || state_q == CAP || state_q == WR) begin
        state_d = ERROR;
        err_d   = ERR_ABORT;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: start_load = i_start;
        RD:   state_d = CAP;
        CAP: begin
          cfg_data_d  = i_rom_data;
          cfg_addr_d  = map_addr(k_q, FIR_K);
          cfg_valid_d = 1'b1;
          state_d     = WR;
        end
        WR: if (i_config_ready) begin
          cfg_valid_d = 1'b0;
          words_d     = words_q + 7'd1;
          if (k_q == LAST_K) begin
            enable_d = 1'b1;
            state_d  = ENA;
          end else begin
            k_d        = k_q + 7'd1;
            rom_addr_d = k_q + 7'd1;
            rom_rd_d   = 1'b1;
            state_d    = RD;
          end
        end
        ENA: begin
          wd_clear = 1'b1;
          state_d  = WAIT1;
        end
        WAIT1, RUN: begin
          if (i_dec_error || (state_q == RUN && wd_tc)) begin
            err_d     = i_dec_error ? ERR_DATAPATH : ERR_WATCHDOG;
            enable_d  = 1'b0;
            running_d = 1'b0;
            state_d   = ERROR;
          end else if (state_q == WAIT1) begin
            if (i_dec_valid) begin
              running_d = 1'b1;
              state_d   = RUN;
            end
          end else begin
            wd_enable = 1'b1;
            wd_clear  = i_dec_valid;
          end
        end
        ERROR: begin
          start_load = i_start || auto_go;
`ifdef SSEMI_DEC_SEQ_AUTO_RESTART_EN
          if (!i_start && auto_go && restart_cnt_q != 8'hFF)
            restart_cnt_d = restart_cnt_q + 8'd1;
`endif
        end
        default: state_d = IDLE;
      endcase
      if (start_load) begin
        state_d    = RD;
        err_d      = ERR_NONE;
        k_d        = 7'd0;
        rom_addr_d = 7'd0;
        rom_rd_d   = 1'b1;
        words_d    = 7'd0;
      end
    end
    busy_d  = !(state_d == IDLE || state_d == ERROR);
    error_d = (state_d == ERROR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      err_q       <= ERR_NONE;
      k_q         <= 7'd0;
      rom_addr_q  <= 7'd0;
      rom_rd_q    <= 1'b0;
      words_q     <= 7'd0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= 8'd0;
      cfg_data_q  <= 32'd0;
      enable_q    <= 1'b0;
      running_q   <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef SSEMI_DEC_SEQ_AUTO_RESTART_EN
      restart_cnt_q <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      k_q         <= k_d;
      rom_addr_q  <= rom_addr_d;
      rom_rd_q    <= rom_rd_d;
      words_q     <= words_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      enable_q    <= enable_d;
      running_q   <= running_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
`ifdef SSEMI_DEC_SEQ_AUTO_RESTART_EN
      restart_cnt_q <= restart_cnt_d;
`endif
    end
  end

  assign o_rom_addr      = rom_addr_q;
  assign o_rom_rd        = rom_rd_q;
  assign o_config_valid  = cfg_valid_q;
  assign o_config_addr   = cfg_addr_q;
  assign o_config_data   = cfg_data_q;
  assign o_enable        = enable_q;
  assign o_running       = running_q;
  assign o_busy          = busy_q;
  assign o_error         = error_q;
  assign o_error_type    = err_q;
  assign o_words_written = words_q;

endmodule

// File: tb/tb_ssemi_decimator_sequencer.sv
// tb/tb_ssemi_decimator_sequencer.sv - scoreboard bench for the decimator sequencer
module tb_ssemi_decimator_sequencer;

  localparam int FIR = 4, HB = 5, WD = 8, HO = 4, NW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, abort = 1'b0, ready = 1'b1;
  logic        dec_valid = 1'b0, dec_error = 1'b0;
  logic [31:0] rom_data = 32'd0;
  logic [6:0]  rom_addr, words;
  logic        rom_rd, cfg_valid, enable, running, busy, error;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [1:0]  error_type;
`ifdef SSEMI_DEC_SEQ_AUTO_RESTART_EN
  logic [7:0]  restart_count;
`endif

  int cyc = 0, n_cmp = 0, n_bad = 0, t0 = 0;
  logic [31:0] rom [128];
  logic [7:0]  exp_addr [NW] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13,
                                  8'h80, 8'h81, 8'h82, 8'h83, 8'h84};
  logic [39:0] sb_q [$];
  logic [39:0] exp_w;

  ssemi_decimator_sequencer #(
    .FIR_TAPS(FIR), .HALFBAND_TAPS(HB), .WATCHDOG_CYCLES(WD), .RESTART_HOLDOFF(HO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .o_rom_addr(rom_addr), .o_rom_rd(rom_rd), .i_rom_data(rom_data),
    .o_config_valid(cfg_valid), .o_config_addr(cfg_addr), .o_config_data(cfg_data),
    .i_config_ready(ready), .o_enable(enable), .i_dec_valid(dec_valid),
    .i_dec_error(dec_error), .o_running(running), .o_busy(busy), .o_error(error),
    .o_error_type(error_type),
`ifdef SSEMI_DEC_SEQ_AUTO_RESTART_EN
    .o_restart_count(restart_count),
`endif
    .o_words_written(words)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !abort && cfg_valid && ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cfg_unexpected: handshake addr %0h data %0h expected none", cfg_addr, cfg_data);
      end else begin
        exp_w = sb_q.pop_front();
        check("cfg_addr", 32'(cfg_addr), 32'(exp_w[39:32]));
        check("cfg_data", cfg_data, exp_w[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int k = 0; k < n; k++) sb_q.push_back({exp_addr[k], rom[k]});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_enable(input string name, input int exp_cycles);
    int n = 0;
    while (!enable && n < 300) begin tick(); n++; end
    check(name, 32'(cyc - t0 + 1), 32'(exp_cycles));
  endtask

  task automatic wait_wr(input string name, input logic [7:0] addr);
    int n = 0;
    while (!(cfg_valid && cfg_addr == addr) && n < 300) begin tick(); n++; end
    check(name, 32'(n < 300), 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({pfx, "_rom_rd"}, 32'(rom_rd), 32'd0);
    check({pfx, "_cfg_valid"}, 32'(cfg_valid), 32'd0);
    check({pfx, "_cfg_addr"}, 32'(cfg_addr), 32'd0);
    check({pfx, "_cfg_data"}, cfg_data, 32'd0);
    check({pfx, "_flags"}, 32'({enable, running, busy, error}), 32'd0);
    check({pfx, "_err_type"}, 32'(error_type), 32'd0);
    check({pfx, "_words"}, 32'(words), 32'd0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 128; k++) rom[k] = {8'hA5, 8'(k), 16'hC3E1 ^ 16'(k * 613)};
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // nominal load, ready always high
    push_words(NW);
    do_start();
    wait_enable("load_cycles", 31);
    check("load_words", 32'(words), 32'd10);
    check("load_busy", 32'(busy), 32'd1);
    tick();
    check("wait1_running", 32'(running), 32'd0);
    dec_valid = 1'b1; tick(); dec_valid = 1'b0;
    check("first_valid_running", 32'(running), 32'd1);

    // watchdog: valids stop in RUN
    repeat (5) tick();
    dec_valid = 1'b1; tick(); dec_valid = 1'b0;
    n = 0;
    while (enable && n < 40) begin tick(); n++; end
    check("wd_cycles", 32'(n), 32'd9);
    check("wd_err_type", 32'(error_type), 32'd2);
    check("wd_flags", 32'({enable, running, busy, error}), 32'b0001);

    // stall of 5 cycles on word 3, started from ERROR
    push_words(NW);
    do_start();
    check("restart_err_type", 32'(error_type), 32'd0);
    check("restart_busy_err", 32'({busy, error}), 32'b10);
    n = 0;
    while (!(rom_rd && rom_addr == 7'd3) && n < 100) begin tick(); n++; end
    check("stall_find_rd3", 32'(n < 100), 32'd1);
    ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(cfg_valid), 32'd1);
      check("stall_addr", 32'(cfg_addr), 32'h12);
      check("stall_data", cfg_data, rom[3]);
      check("stall_words", 32'(words), 32'd3);
      tick();
    end
    ready = 1'b1;
    wait_enable("stall_cycles", 36);

    // abort outside a load returns to IDLE
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle_flags", 32'({enable, running, busy, error}), 32'b0000);

    // abort together with the 6th ready
    push_words(5);
    do_start();
    wait_wr("abort_find_wr80", 8'h80);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_cfg_valid", 32'(cfg_valid), 32'd0);
    check("abort_err_type", 32'(error_type), 32'd3);
    check("abort_words", 32'(words), 32'd5);
    check("abort_flags", 32'({enable, busy, error}), 32'b001);
    check("abort_sb_empty", 32'(sb_q.size()), 32'd0);

    // reset in the middle of WR, then a clean reload
    push_words(2);
    do_start();
    wait_wr("rst_find_wr11", 8'h11);
    rst = 1'b1; tick(); rst = 1'b0;
    check_all_zero("midrst");
    check("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
    push_words(NW);
    do_start();
    wait_enable("reload_cycles", 31);
    check("reload_words", 32'(words), 32'd10);

    // datapath error in the same cycle the watchdog hits its terminal count
    tick();
    dec_valid = 1'b1; tick(); dec_valid = 1'b0;
    repeat (8) tick();
    check("prec_still_enabled", 32'(enable), 32'd1);
    dec_error = 1'b1; tick(); dec_error = 1'b0;
    check("prec_err_type", 32'(error_type), 32'd1);
    check("prec_flags", 32'({enable, running, busy, error}), 32'b0001);
    repeat (10) tick();
`ifdef SSEMI_DEC_SEQ_AUTO_RESTART_EN
    check("auto_restart_count", 32'(restart_count), 32'd1);
`else
    check("no_auto_restart", 32'({busy, error}), 32'b01);
`endif
    repeat (40) tick();
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
